// File: rtl/snake_pkg.sv
// Shared Snake types: direction encodings, PS/2 scancodes, decoder states.
package snake_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } dec_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  function automatic dir_t dir_opposite(dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_NONE;
    endcase
  endfunction

  function automatic dir_t arrow_dir(logic [7:0] b);
    case (b)
      SC_UP:    return DIR_UP;
      SC_DOWN:  return DIR_DOWN;
      SC_LEFT:  return DIR_LEFT;
      SC_RIGHT: return DIR_RIGHT;
      default:  return DIR_NONE;
    endcase
  endfunction

  function automatic dir_t wasd_dir(logic [7:0] b);
    case (b)
      SC_W:    return DIR_UP;
      SC_S:    return DIR_DOWN;
      SC_A:    return DIR_LEFT;
      SC_D:    return DIR_RIGHT;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 pin synchroniser, clock glitch filter, 11-bit deframer with parity check and
// partial-frame watchdog. rx_vld/frame_err pulse the cycle after the stop-bit edge.
module ps2_frame_rx
  import snake_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_US = 2000,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       kclk,
  input  logic       kdata,
  output logic [7:0] rx_byte,
  output logic       rx_vld,
  output logic       frame_err
);

  localparam int TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int WD_W   = $clog2(TO_CYC + 1);
  localparam int FC_W   = $clog2(FILTER_LEN + 1);

  logic [1:0]      clk_sync;
  logic [1:0]      dat_sync;
  logic            clk_s;
  logic            dat_s;
  logic            filt;
  logic [FC_W-1:0] fcnt;
  logic            fall;
  logic [10:0]     shreg;
  logic [10:0]     frame;
  logic            frame_ok;
  logic [3:0]      bit_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // A falling edge is the cycle the filter commits to low.
  assign fall     = filt & ~clk_s & (fcnt == FC_W'(FILTER_LEN - 1));
  assign frame    = {dat_s, shreg[10:1]};
  assign frame_ok = ~frame[0] & (^frame[9:1]) & frame[10];
  assign wd_hit   = (bit_cnt != 4'd0) && (wd_cnt == WD_W'(TO_CYC - 1));

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      fcnt     <= '0;
    end else begin
      clk_sync <= {clk_sync[0], kclk};
      dat_sync <= {dat_sync[0], kdata};
      if (clk_s == filt) begin
        fcnt <= '0;
      end else if (fcnt == FC_W'(FILTER_LEN - 1)) begin
        filt <= clk_s;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      wd_cnt    <= '0;
      rx_byte   <= '0;
      rx_vld    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_vld    <= 1'b0;
      frame_err <= 1'b0;
      // An accepted edge always beats a coincident watchdog expiry.
      if (fall) begin
        shreg  <= frame;
        wd_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            rx_byte <= frame[8:1];
            rx_vld  <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (wd_hit) begin
          bit_cnt   <= '0;
          wd_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_move_rx.sv
// PS/2 keyboard to snake direction: E0/F0 prefix tracking, reversal-safe latched move.
// Optional PS2_WASD_EN lets unprefixed W/A/S/D make codes steer as well.
module ps2_move_rx
  import snake_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_US = 2000,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       kclk,
  input  logic       kdata,
  output logic [2:0] move,
  output logic       move_vld,
  output logic [7:0] rx_byte,
  output logic       rx_vld,
  output logic       frame_err
);

  dec_state_t state;
  dec_state_t state_nxt;
  dir_t       move_q;
  dir_t       cand;
  logic       accept;

  ps2_frame_rx #(
    .CLK_HZ    (CLK_HZ),
    .TIMEOUT_US(TIMEOUT_US),
    .FILTER_LEN(FILTER_LEN)
  ) u_frame (
    .clk      (clk),
    .arst     (arst),
    .kclk     (kclk),
    .kdata    (kdata),
    .rx_byte  (rx_byte),
    .rx_vld   (rx_vld),
    .frame_err(frame_err)
  );

  always_comb begin
    state_nxt = state;
    cand      = DIR_NONE;
    case (state)
      IDLE: begin
        if (rx_byte == SC_EXT) begin
          state_nxt = EXT;
        end else if (rx_byte == SC_BRK) begin
          state_nxt = BRK;
        end else begin
`ifdef PS2_WASD_EN
          cand = wasd_dir(rx_byte);
`else
          cand = DIR_NONE;
`endif
        end
      end
      EXT: begin
        if (rx_byte == SC_BRK) begin
          state_nxt = EXT_BRK;
        end else begin
          cand      = arrow_dir(rx_byte);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Held-key repeats and instant reversals are both dropped here.
  assign accept = (cand != DIR_NONE) && (cand != move_q) && (cand != dir_opposite(move_q));
  assign move   = move_q;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state    <= IDLE;
      move_q   <= DIR_NONE;
      move_vld <= 1'b0;
    end else begin
      move_vld <= 1'b0;
      if (rx_vld) begin
        state <= state_nxt;
        if (accept) begin
          move_q   <= cand;
          move_vld <= 1'b1;
        end
      end
    end
  end

endmodule
